// File: rtl/div_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types for the divider result buffer: tag, result
//               record, control state and result-assembly helper.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH     = 32;
    localparam int DIV_TAG_WIDTH = 4;

    typedef logic [DIV_TAG_WIDTH-1:0] div_tag_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] quotient;
        logic [DIV_WIDTH-1:0] remainder;
        div_tag_t             tag;
        logic                 error;
    } div_result_t;

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } div_state_t;

    // A divide by zero reports an all-ones quotient; the remainder is kept.
    function automatic div_result_t make_result(
        input logic [DIV_WIDTH-1:0] quotient,
        input logic [DIV_WIDTH-1:0] remainder,
        input div_tag_t             tag,
        input logic                 zero
    );
        div_result_t res;
        res.quotient  = zero ? '1 : quotient;
        res.remainder = remainder;
        res.tag       = tag;
        res.error     = zero;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_result_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : div_result_fifo
// Description : First-word-fall-through FIFO of div_result_t records with
//               simultaneous push/pop at any occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module div_result_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_in,
    input  div_result_t              data_in,
    input  logic                     pop_in,
    output div_result_t              data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int c_aw = $clog2(DEPTH);

    div_result_t       r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == (c_aw+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop_in & ~w_empty;
    // When full, a push is only accepted if the head leaves in the same cycle.
    assign w_do_push = push_in & (~w_full | w_do_pop);

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out  = r_mem[r_rd_ptr];
    assign full_out  = w_full;
    assign empty_out = w_empty;
    assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/div_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : div_result_buffer
// Description : Re-attaches tag/zero flags to fixed-latency divider results,
//               buffers them and issues credits so the buffer never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module div_result_buffer
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter int TAG_WIDTH = DIV_TAG_WIDTH,
    parameter int LATENCY   = 16,
    parameter int DEPTH     = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     issue_valid_in,
    input  logic [TAG_WIDTH-1:0]     issue_tag_in,
    input  logic                     issue_zero_in,
    output logic                     issue_ok_out,
    input  logic                     div_valid_in,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    output logic                     res_valid_out,
    input  logic                     res_ready_in,
    output logic [WIDTH-1:0]         res_quotient_out,
    output logic [WIDTH-1:0]         res_remainder_out,
    output logic [TAG_WIDTH-1:0]     res_tag_out,
    output logic                     res_error_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic [$clog2(DEPTH):0]   in_flight_out,
    output logic                     protocol_error_out
);

    localparam int                   c_cnt_w      = $clog2(DEPTH) + 1;
    localparam int                   c_drain_w    = $clog2(LATENCY) + 1;
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(LATENCY - 1);

    div_state_t               r_state;
    logic [c_drain_w-1:0]     r_drain_cnt;
    logic [c_cnt_w-1:0]       r_in_flight;
    logic                     r_protocol_error;

    // Delay line mirroring the divider pipeline: valid, tag and zero flag.
    logic [LATENCY-1:0]       r_dl_valid;
    logic [TAG_WIDTH-1:0]     r_dl_tag  [LATENCY];
    logic                     r_dl_zero [LATENCY];

    logic                     w_run;
    logic                     w_issue_ok;
    logic                     w_issue_tracked;
    logic                     w_issue_violation;
    logic                     w_last_valid;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_mismatch;
    logic                     w_overflow;
    logic [c_cnt_w:0]         w_committed;
    logic                     w_full;
    logic                     w_empty;
    logic [c_cnt_w-1:0]       w_count;
    div_result_t              w_wr_data;
    div_result_t              w_head;

    assign w_run             = (r_state == ST_RUN);
    assign w_committed       = {1'b0, r_in_flight} + {1'b0, w_count};
    assign w_issue_ok        = w_run & (w_committed < (c_cnt_w+1)'(DEPTH));
    assign w_issue_tracked   = issue_valid_in & w_issue_ok;
    assign w_issue_violation = w_run & issue_valid_in & ~w_issue_ok;

    assign w_last_valid = r_dl_valid[LATENCY-1];
    assign w_push       = w_run & div_valid_in & w_last_valid;
    assign w_mismatch   = w_run & (div_valid_in ^ w_last_valid);
    assign w_pop        = ~w_empty & res_ready_in;
    assign w_overflow   = w_push & w_full & ~w_pop;

    assign w_wr_data = make_result(div_quotient_in, div_remainder_in,
                                   r_dl_tag[LATENCY-1], r_dl_zero[LATENCY-1]);

    // DRAIN holds off credits for one full divider latency after reset so any
    // result launched before reset has left the pipeline.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    if (r_drain_cnt == c_drain_last) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_DRAIN;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_dl_valid <= '0;
        end else begin
            r_dl_valid <= {r_dl_valid[LATENCY-2:0], w_issue_tracked};
        end
    end

    always_ff @(posedge clk_in) begin
        r_dl_tag[0]  <= issue_tag_in;
        r_dl_zero[0] <= issue_zero_in;
        for (int i = 1; i < LATENCY; i++) begin
            r_dl_tag[i]  <= r_dl_tag[i-1];
            r_dl_zero[i] <= r_dl_zero[i-1];
        end
    end

    // A request leaving the delay line is no longer in flight, even when the
    // divider failed to return it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_in_flight <= '0;
        end else begin
            case ({w_issue_tracked, w_last_valid})
                2'b10:   r_in_flight <= r_in_flight + c_cnt_w'(1);
                2'b01:   r_in_flight <= r_in_flight - c_cnt_w'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_protocol_error <= 1'b0;
        end else if (w_mismatch | w_overflow | w_issue_violation) begin
            r_protocol_error <= 1'b1;
        end
    end

    div_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (w_push),
        .data_in   (w_wr_data),
        .pop_in    (w_pop),
        .data_out  (w_head),
        .full_out  (w_full),
        .empty_out (w_empty),
        .count_out (w_count)
    );

    assign issue_ok_out       = w_issue_ok;
    assign res_valid_out      = ~w_empty;
    assign res_quotient_out   = w_head.quotient;
    assign res_remainder_out  = w_head.remainder;
    assign res_tag_out        = w_head.tag;
    assign res_error_out      = w_head.error;
    assign count_out          = w_count;
    assign in_flight_out      = r_in_flight;
    assign protocol_error_out = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_div_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_result_buffer
// Description : Scoreboard bench for div_result_buffer with a scheduled
//               fixed-latency divider return model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_result_buffer;

    localparam int L = 16;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        issue_valid_in = 1'b0;
    logic [3:0]  issue_tag_in = '0;
    logic        issue_zero_in = 1'b0;
    logic        issue_ok_out;
    logic        div_valid_in = 1'b0;
    logic [31:0] div_quotient_in = '0;
    logic [31:0] div_remainder_in = '0;
    logic        res_valid_out;
    logic        res_ready_in = 1'b1;
    logic [31:0] res_quotient_out;
    logic [31:0] res_remainder_out;
    logic [3:0]  res_tag_out;
    logic        res_error_out;
    logic [2:0]  count_out;
    logic [2:0]  in_flight_out;
    logic        protocol_error_out;

    div_result_buffer #(
        .WIDTH(32), .TAG_WIDTH(4), .LATENCY(L), .DEPTH(4)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .issue_valid_in     (issue_valid_in),
        .issue_tag_in       (issue_tag_in),
        .issue_zero_in      (issue_zero_in),
        .issue_ok_out       (issue_ok_out),
        .div_valid_in       (div_valid_in),
        .div_quotient_in    (div_quotient_in),
        .div_remainder_in   (div_remainder_in),
        .res_valid_out      (res_valid_out),
        .res_ready_in       (res_ready_in),
        .res_quotient_out   (res_quotient_out),
        .res_remainder_out  (res_remainder_out),
        .res_tag_out        (res_tag_out),
        .res_error_out      (res_error_out),
        .count_out          (count_out),
        .in_flight_out      (in_flight_out),
        .protocol_error_out (protocol_error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          ret_v [int];
    logic [31:0] ret_q [int];
    logic [31:0] ret_r [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Divider model: returns are sampled LATENCY edges after the issue edge.
    initial begin
        forever begin
            @(posedge clk_in);
            cyc++;
            #2;
            if (ret_v.exists(cyc + 1)) begin
                div_valid_in     = 1'b1;
                div_quotient_in  = ret_q[cyc + 1];
                div_remainder_in = ret_r[cyc + 1];
            end else begin
                div_valid_in     = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compares every accepted result with the oldest expectation.
    always @(negedge clk_in) begin
        if (res_valid_out && res_ready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {60'd0, res_tag_out}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_quotient",  res_quotient_out,  e.q);
                check("res_remainder", res_remainder_out, e.r);
                check("res_tag",       res_tag_out,       e.tag);
                check("res_error",     res_error_out,     e.err);
            end
        end
    end

    // Called at #1 after an edge; the issue is sampled at the next edge.
    task automatic do_issue(input logic [3:0] tag, input logic zero,
                            input logic [31:0] dq, input logic [31:0] dr);
        exp_t e;
        for (int n = 0; n < 200 && !issue_ok_out; n++) begin
            @(posedge clk_in); #1;
        end
        check("issue_credit_wait", issue_ok_out, 1);
        issue_valid_in = 1'b1;
        issue_tag_in   = tag;
        issue_zero_in  = zero;
        ret_v[cyc + 1 + L] = 1'b1;
        ret_q[cyc + 1 + L] = dq;
        ret_r[cyc + 1 + L] = dr;
        e.q = zero ? 32'hFFFF_FFFF : dq;
        e.r = dr;
        e.tag = tag;
        e.err = zero;
        exp_q.push_back(e);
        @(posedge clk_in); #1;
        issue_valid_in = 1'b0;
        issue_zero_in  = 1'b0;
    endtask

    task automatic drain_check();
        ret_v[cyc + 5] = 1'b1;
        ret_q[cyc + 5] = 32'hDEAD;
        ret_r[cyc + 5] = 32'hBEEF;
        for (int k = 0; k < L; k++) begin
            check("drain_issue_ok", issue_ok_out, 0);
            check("drain_perr", protocol_error_out, 0);
            check("drain_count", count_out, 0);
            @(posedge clk_in); #1;
        end
        check("drain_end_issue_ok", issue_ok_out, 1);
        check("drain_end_perr", protocol_error_out, 0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && (count_out != 0 || in_flight_out != 0); n++) begin
            @(posedge clk_in); #1;
        end
        check("idle_count", count_out, 0);
        check("idle_in_flight", in_flight_out, 0);
    endtask

    initial begin
        #2 rst_in = 1'b1;
        #1;
        check("rst_issue_ok", issue_ok_out, 0);
        check("rst_res_valid", res_valid_out, 0);
        check("rst_count", count_out, 0);
        check("rst_in_flight", in_flight_out, 0);
        check("rst_perr", protocol_error_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // 1. Drain with a stale return pulse
        drain_check();

        // 2. Single request, exact latency
        do_issue(4'd3, 1'b0, 32'd7, 32'd2);
        repeat (L - 1) begin @(posedge clk_in); #1; end
        check("single_not_yet_valid", res_valid_out, 0);
        check("single_in_flight", in_flight_out, 1);
        @(posedge clk_in); #1;
        check("single_valid", res_valid_out, 1);
        wait_idle();

        // 3. Divide by zero
        do_issue(4'd5, 1'b1, 32'h1234, 32'h77);
        wait_idle();

        // 4. Backpressure and credit return
        res_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) do_issue(4'(i), 1'b0, 32'(100 + i), 32'(i));
        check("bp_credit_gone", issue_ok_out, 0);
        check("bp_in_flight", in_flight_out, 4);
        for (int n = 0; n < 100 && count_out != 4; n++) begin @(posedge clk_in); #1; end
        check("bp_count_full", count_out, 4);
        check("bp_credit_still_gone", issue_ok_out, 0);
        check("bp_head_tag", res_tag_out, 0);
        repeat (3) begin @(posedge clk_in); #1; end
        check("bp_hold_tag", res_tag_out, 0);
        check("bp_hold_q", res_quotient_out, 100);
        res_ready_in = 1'b1;
        @(posedge clk_in); #1;
        check("bp_credit_back", issue_ok_out, 1);
        check("bp_count_after_pop", count_out, 3);
        wait_idle();

        // 5. Spurious divider return
        ret_v[cyc + 1] = 1'b1;
        ret_q[cyc + 1] = 32'h55;
        ret_r[cyc + 1] = 32'h66;
        check("perr_before", protocol_error_out, 0);
        @(posedge clk_in); #1;
        check("perr_set", protocol_error_out, 1);
        check("perr_count", count_out, 0);
        repeat (3) begin @(posedge clk_in); #1; end
        check("perr_sticky", protocol_error_out, 1);

        // 6. Async reset with 2 buffered and 1 in flight
        res_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) do_issue(4'(8 + i), 1'b0, 32'(200 + i), 32'(i));
        for (int n = 0; n < 100 && !(count_out == 2 && in_flight_out == 1); n++) begin
            @(posedge clk_in); #1;
        end
        check("arst_pre_count", count_out, 2);
        check("arst_pre_in_flight", in_flight_out, 1);
        #2 rst_in = 1'b1;
        exp_q.delete();
        #1;
        check("arst_res_valid", res_valid_out, 0);
        check("arst_count", count_out, 0);
        check("arst_in_flight", in_flight_out, 0);
        check("arst_perr", protocol_error_out, 0);
        check("arst_issue_ok", issue_ok_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        res_ready_in = 1'b1;
        drain_check();

        // Recovery after reset
        do_issue(4'd9, 1'b0, 32'd142, 32'd6);
        wait_idle();
        repeat (2) begin @(posedge clk_in); #1; end
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        check("final_perr", protocol_error_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
